fpu_divsqrt_arbiter: RTL and testbench

FPU_DIVSQRT_ARBITER -- requirements
Module: fpu_divsqrt_arbiter

---
 rtl/fpu_divsqrt_arbiter.sv | 168 ++++++++++++++++
 tb/tb_fpu_divsqrt_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_divsqrt_arbiter.sv
// Two-requester round-robin front end for one shared div/sqrt unit, one op in flight.
// Latency: grant-to-response is 3 cycles minimum. The optional BUSY watchdog is enabled by FPU_DIVSQRT_ARB_TIMEOUT_EN.
// Backpressure: holds the issue until unit_ready_i and the response until rsp_ready_i. No grant is made while an op is outstanding.
module fpu_divsqrt_arbiter #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [1:0]          req_op_i,
  input  logic [2*DATA_W-1:0] req_a_i,
  input  logic [2*DATA_W-1:0] req_b_i,
  output logic                unit_valid_o,
  input  logic                unit_ready_i,
  output logic                unit_op_o,
  output logic [DATA_W-1:0]   unit_a_o,
  output logic [DATA_W-1:0]   unit_b_o,
  input  logic                unit_done_i,
  input  logic [DATA_W-1:0]   unit_result_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_id_o,
  output logic [DATA_W-1:0]   rsp_result_o,
  output logic                rsp_err_o,
  input  logic                flush_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..255");
  end

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                id_q, id_d;
  logic                op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                win;
  logic                any_req;

`ifdef FPU_DIVSQRT_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
`endif

  // The pointer names the favoured requester; fall back to the other one.
  assign any_req = |req_valid_i;
  assign win     = req_valid_i[ptr_q] ? ptr_q : ~ptr_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    req_ready_o  = '0;
    unit_valid_o = 1'b0;
    rsp_valid_o  = 1'b0;
`ifdef FPU_DIVSQRT_ARB_TIMEOUT_EN
    err_d        = err_q;
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready_o[win] = 1'b1;
          id_d    = win;
          op_d    = req_op_i[win];
          a_d     = win ? req_a_i[2*DATA_W-1:DATA_W] : req_a_i[DATA_W-1:0];
          b_d     = win ? req_b_i[2*DATA_W-1:DATA_W] : req_b_i[DATA_W-1:0];
          ptr_d   = ~win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        unit_valid_o = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else if (unit_ready_i) begin
          state_d = BUSY;
`ifdef FPU_DIVSQRT_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        // Flush beats a coincident completion; the result is dropped.
        if (flush_i) begin
          state_d = IDLE;
        end else if (unit_done_i) begin
          res_d   = unit_result_i;
          state_d = RESP;
`ifdef FPU_DIVSQRT_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef FPU_DIVSQRT_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO_LIM) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
`endif
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef FPU_DIVSQRT_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifdef FPU_DIVSQRT_ARB_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign unit_op_o    = op_q;
  assign unit_a_o     = a_q;
  assign unit_b_o     = b_q;
  assign rsp_id_o     = id_q;
  assign rsp_result_o = res_q;
`ifdef FPU_DIVSQRT_ARB_TIMEOUT_EN
  assign rsp_err_o    = err_q;
`else
  assign rsp_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_divsqrt_arbiter.sv
// Scoreboard bench for fpu_divsqrt_arbiter: a round-robin grant model and a stand-in div/sqrt unit.
module tb_fpu_divsqrt_arbiter;
  localparam int DW   = 32;
  localparam int TO   = 4;
  localparam int NOPS = 60;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [1:0]      req_valid_i;
  logic [1:0]      req_ready_o;
  logic [1:0]      req_op_i;
  logic [2*DW-1:0] req_a_i, req_b_i;
  logic            unit_valid_o, unit_ready_i, unit_op_o;
  logic [DW-1:0]   unit_a_o, unit_b_o;
  logic            unit_done_i;
  logic [DW-1:0]   unit_result_i;
  logic            rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_err_o;
  logic [DW-1:0]   rsp_result_o;
  logic            flush_i;

  fpu_divsqrt_arbiter #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i), .unit_op_o(unit_op_o),
    .unit_a_o(unit_a_o), .unit_b_o(unit_b_o),
    .unit_done_i(unit_done_i), .unit_result_i(unit_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o), .flush_i(flush_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic id; logic [DW-1:0] res; logic err; } rsp_t;
  typedef struct packed { logic op; logic [DW-1:0] a; logic [DW-1:0] b; } iss_t;

  rsp_t exp_q[$];
  iss_t iss_q[$];
  int   gnt_log[$];
  int   checks = 0;
  int   errors = 0;
  logic last_gnt = 1'b1;
  logic busy_m = 1'b0;
  logic [1:0] gnt_seen = 2'b00;
  bit   auto_unit = 1'b1;
  int   done_wait = -1;
  logic [DW-1:0] done_res = '0;

  // Stand-in unit: exponent arithmetic, exact for powers of two (div: a/b, sqrt: sqrt(a)).
  function automatic logic [DW-1:0] ref_fn(logic op, logic [DW-1:0] a, logic [DW-1:0] b);
    return op ? (a >> 1) + 32'h1FC0_0000 : a - b + 32'h3F80_0000;
  endfunction

  task automatic check(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: grant model, issue check, response scoreboard.
  always @(negedge clk_i) begin : mon
    logic w;
    iss_t ri;
    rsp_t e;
    if (rst_ni && req_ready_o != 2'b00) begin
      w = (req_valid_i == 2'b11) ? ~last_gnt : req_valid_i[1];
      check("grant_onehot", 96'(req_ready_o), 96'(2'b01 << w));
      check("one_outstanding", 96'(busy_m), 96'(0));
      ri.op = req_op_i[w];
      ri.a  = w ? req_a_i[2*DW-1:DW] : req_a_i[DW-1:0];
      ri.b  = w ? req_b_i[2*DW-1:DW] : req_b_i[DW-1:0];
      iss_q.push_back(ri);
      e.id  = w;
      e.res = ref_fn(ri.op, ri.a, ri.b);
      e.err = 1'b0;
      exp_q.push_back(e);
      last_gnt    = w;
      gnt_seen[w] = 1'b1;
      busy_m      = 1'b1;
      gnt_log.push_back(int'(w));
    end
    if (rst_ni && unit_valid_o && unit_ready_i) begin
      check("issue_expected", 96'(iss_q.size() != 0), 96'(1));
      if (iss_q.size() != 0) begin
        ri = iss_q.pop_front();
        check("issue_fields", 96'({unit_op_o, unit_a_o, unit_b_o}), 96'(ri));
      end
      if (auto_unit) done_wait = int'($urandom_range(0, 3));
      done_res = ref_fn(unit_op_o, unit_a_o, unit_b_o);
    end
    if (rst_ni && rsp_valid_o && rsp_ready_i) begin
      check("rsp_expected", 96'(exp_q.size() != 0), 96'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_id", 96'(rsp_id_o), 96'(e.id));
        check("rsp_result", 96'(rsp_result_o), 96'(e.res));
        check("rsp_err", 96'(rsp_err_o), 96'(e.err));
      end
      busy_m = 1'b0;
    end
  end

  // Unit completion driver.
  always @(posedge clk_i) begin
    #1;
    unit_done_i = 1'b0;
    if (done_wait == 0) begin
      unit_done_i   = 1'b1;
      unit_result_i = done_res;
      done_wait     = -1;
    end else if (done_wait > 0) begin
      done_wait--;
    end
  end

  task automatic send_one(int n, logic op, logic [DW-1:0] a, logic [DW-1:0] b);
    int i = 0;
    @(posedge clk_i); #1;
    req_valid_i[n]         = 1'b1;
    req_op_i[n]            = op;
    req_a_i[n*DW +: DW]    = a;
    req_b_i[n*DW +: DW]    = b;
    do begin
      @(posedge clk_i); #1;
      i++;
    end while (!gnt_seen[n] && i < 50);
    check("grant_seen", 96'(gnt_seen[n]), 96'(1));
    req_valid_i[n] = 1'b0;
    gnt_seen[n]    = 1'b0;
  endtask

  task automatic wait_issue(string name);
    int i = 0;
    bit ok = 1'b0;
    while (!ok && i < 50) begin
      @(negedge clk_i);
      i++;
      ok = unit_valid_o && unit_ready_i;
    end
    check(name, 96'(ok), 96'(1));
  endtask

  task automatic drain(string name, int bound);
    int i = 0;
    while ((exp_q.size() != 0 || busy_m) && i < bound) begin
      @(negedge clk_i);
      i++;
    end
    check(name, 96'(exp_q.size()), 96'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt, sent, loaded;
    bit found;
    rsp_t e;
    rst_ni = 1'b0; req_valid_i = '0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
    unit_ready_i = 1'b0; unit_done_i = 1'b0; unit_result_i = '0;
    rsp_ready_i = 1'b0; flush_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ctrl", 96'({req_ready_o, unit_valid_o, rsp_valid_o, unit_op_o, rsp_id_o, rsp_err_o}), 96'(0));
    check("rst_data", {unit_a_o, unit_b_o, rsp_result_o}, 96'(0));
    rst_ni = 1'b1;

    // Single divide, minimum latency
    unit_ready_i = 1'b1; rsp_ready_i = 1'b1; auto_unit = 1'b0;
    send_one(0, 1'b0, 32'h4080_0000, 32'h4000_0000);
    lat = 0; found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk_i);
      if (unit_valid_o && unit_ready_i) done_wait = 0;
      if (rsp_valid_o) begin lat = i; found = 1'b1; end
    end
    check("latency", 96'(lat), 96'(3));
    check("div_result", 96'(rsp_result_o), 96'(32'h4000_0000));
    check("div_id", 96'(rsp_id_o), 96'(0));
    drain("div_drain", 20);

    // Randomised traffic
    auto_unit = 1'b1; sent = 0; gnt_seen = 2'b00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk_i); #1;
      for (int n = 0; n < 2; n++) begin
        if (gnt_seen[n]) begin req_valid_i[n] = 1'b0; gnt_seen[n] = 1'b0; end
        if (!req_valid_i[n] && sent < NOPS && $urandom_range(0, 2) != 0) begin
          req_valid_i[n]      = 1'b1;
          req_op_i[n]         = ($urandom_range(0, 1) != 0);
          req_a_i[n*DW +: DW] = $urandom;
          req_b_i[n*DW +: DW] = $urandom;
          sent++;
        end
      end
      unit_ready_i = ($urandom_range(0, 3) != 0);
      rsp_ready_i  = ($urandom_range(0, 3) != 0);
      if (sent == NOPS && req_valid_i == 2'b00 && exp_q.size() == 0 && !busy_m) break;
    end
    check("random_sent", 96'(sent), 96'(NOPS));
    check("random_pending", 96'(exp_q.size()), 96'(0));

    // Unit stalls five cycles in ISSUE
    unit_ready_i = 1'b0; rsp_ready_i = 1'b1;
    send_one(1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("stall_valid", 96'(unit_valid_o), 96'(1));
      check("stall_fields", 96'({unit_op_o, unit_a_o, unit_b_o}), {31'd0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678});
    end
    @(posedge clk_i); #1;
    unit_ready_i = 1'b1;
    drain("stall_drain", 30);

    // Flush coincident with completion
    auto_unit = 1'b0;
    send_one(0, 1'b0, $urandom, $urandom);
    wait_issue("flush_issue");
    done_wait = 0;
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    exp_q.delete(); busy_m = 1'b0;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    done_wait = 0;
    cnt = 0;
    repeat (6) begin @(negedge clk_i); if (rsp_valid_o) cnt++; end
    check("flush_no_rsp", 96'(cnt), 96'(0));
    auto_unit = 1'b1;
    send_one(1, 1'b1, 32'h4080_0000, 32'h0);
    drain("flush_next", 30);

    // Reset while BUSY, then a stray completion
    auto_unit = 1'b0;
    send_one(0, 1'b1, $urandom, $urandom);
    wait_issue("rst_issue");
    @(posedge clk_i); #1;
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    check("rst_async_ctrl", 96'({req_ready_o, unit_valid_o, rsp_valid_o, unit_op_o, rsp_id_o, rsp_err_o}), 96'(0));
    check("rst_async_data", {unit_a_o, unit_b_o, rsp_result_o}, 96'(0));
    exp_q.delete(); iss_q.delete(); busy_m = 1'b0; last_gnt = 1'b1; gnt_seen = 2'b00;
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    done_wait = 0;
    cnt = 0;
    repeat (5) begin @(negedge clk_i); if (rsp_valid_o || unit_valid_o) cnt++; end
    check("rst_no_rsp", 96'(cnt), 96'(0));
    check("rst_idle_ctrl", 96'({req_ready_o, unit_valid_o, rsp_valid_o, unit_op_o, rsp_id_o, rsp_err_o}), 96'(0));
    check("rst_idle_data", {unit_a_o, unit_b_o, rsp_result_o}, 96'(0));

    // Both requesters held valid: grants alternate starting at 0
    auto_unit = 1'b1; unit_ready_i = 1'b1; rsp_ready_i = 1'b1;
    gnt_log.delete();
    @(posedge clk_i); #1;
    req_valid_i = 2'b11; req_op_i = 2'b01;
    req_a_i = {$urandom, $urandom}; req_b_i = {$urandom, $urandom};
    loaded = 2;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk_i); #1;
      for (int n = 0; n < 2; n++) begin
        if (gnt_seen[n]) begin
          gnt_seen[n] = 1'b0;
          if (loaded < 4) begin
            req_a_i[n*DW +: DW] = $urandom;
            loaded++;
          end else begin
            req_valid_i[n] = 1'b0;
          end
        end
      end
      if (gnt_log.size() == 4 && exp_q.size() == 0 && !busy_m) break;
    end
    check("alt_count", 96'(gnt_log.size()), 96'(4));
    for (int i = 0; i < gnt_log.size() && i < 4; i++)
      check("alt_order", 96'(gnt_log[i]), 96'(i % 2));

    // Long BUSY with no completion
    auto_unit = 1'b0;
    send_one(1, 1'b1, 32'h4080_0000, 32'h0);
    wait_issue("busy_issue");
`ifdef FPU_DIVSQRT_ARB_TIMEOUT_EN
    e = exp_q.pop_front();
    e.res = '0; e.err = 1'b1;
    exp_q.push_front(e);
    lat = 0; found = 1'b0;
    for (int i = 1; i <= 50 && !found; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin lat = i; found = 1'b1; end
    end
    check("timeout_latency", 96'(lat), 96'(TO + 1));
    drain("timeout_drain", 10);
`else
    e = exp_q[0];
    cnt = 0;
    repeat (100) begin @(negedge clk_i); if (rsp_valid_o) cnt++; end
    check("busy_waits", 96'(cnt), 96'(0));
    check("busy_exp_id", 96'(e.id), 96'(1));
    done_wait = 0;
    drain("busy_drain", 20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
